// File: rtl/byte_data_memory_pkg.sv
// Shared definitions for the byte-addressable data memory: access size
// encodings, legal word widths and a size-to-byte-count helper.
package byte_data_memory_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } size_e;

    localparam int unsigned DATA_WIDTH_32 = 32;
    localparam int unsigned DATA_WIDTH_64 = 64;

    function automatic int unsigned size_bytes(input size_e size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/byte_data_memory_load_align.sv
// Combinational load aligner: shifts the addressed bytes of a memory word
// down to bit 0 and sign- or zero-extends them to the full word width.
module load_align
    import byte_data_memory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OFF_W      = 2
) (
    input  logic [DATA_WIDTH-1:0] raw,
    input  logic [OFF_W-1:0]      offset,
    input  logic [1:0]            size,
    input  logic                  signed_load,
    output logic [DATA_WIDTH-1:0] result
);

    logic [DATA_WIDTH-1:0] shifted;
    int unsigned           msb;
    logic                  ext;

    always_comb begin
        shifted = raw >> {offset, 3'b000};
        result  = '0;
        case (size_e'(size))
            SIZE_BYTE: msb = 7;
            SIZE_HALF: msb = 15;
            SIZE_WORD: msb = 31;
            default:   msb = DATA_WIDTH - 1;
        endcase
        ext = signed_load & shifted[msb];
        // bits above the access width take the extension bit
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            result[i] = (i <= msb) ? shifted[i] : ext;
        end
    end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressable data memory with byte/half/word/dword stores and
// registered, extended loads; misaligned or illegal accesses are flagged.
module byte_data_memory
    import byte_data_memory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemoryRead,
    input  logic                  MemoryWrite,
    input  logic [1:0]            Size,
    input  logic                  SignedLoad,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  ReadValid,
    output logic                  AccessError
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(NBYTES);
    localparam int unsigned DEPTH  = (2 ** ADDR_WIDTH) / NBYTES;
    localparam int unsigned IDX_W  = ADDR_WIDTH - OFF_W;

    logic [NBYTES-1:0][7:0] mem [DEPTH];

    logic [IDX_W-1:0]       idx;
    logic [OFF_W-1:0]       offset;
    logic [OFF_W-1:0]       align_mask;
    logic                   misaligned;
    logic                   illegal;
    logic                   bad;
    logic                   do_read;
    logic                   do_write;
    logic [NBYTES-1:0]      wr_en;
    logic [DATA_WIDTH-1:0]  wr_shift;
    logic [DATA_WIDTH-1:0]  load_result;

    assign idx    = Address[ADDR_WIDTH-1:OFF_W];
    assign offset = Address[OFF_W-1:0];

    // Access legality and byte-lane enables
    always_comb begin
        align_mask = OFF_W'(size_bytes(size_e'(Size)) - 32'd1);
        misaligned = |(offset & align_mask);
        illegal    = (size_e'(Size) == SIZE_DWORD) && (DATA_WIDTH == DATA_WIDTH_32);
        bad        = misaligned | illegal;
        do_read    = MemoryRead & ~bad;
        do_write   = Reset_n & MemoryWrite & ~bad;
        wr_shift   = WriteData << {offset, 3'b000};
        wr_en      = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            wr_en[i] = (i >= 32'(offset)) &&
                       (i < 32'(offset) + size_bytes(size_e'(Size)));
        end
    end

    // Byte-enable write port; contents are deliberately not reset
    always_ff @(posedge Clock) begin
        if (do_write) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (wr_en[i]) begin
                    mem[idx][i] <= wr_shift[8*i +: 8];
                end
            end
        end
    end

    load_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .OFF_W      (OFF_W)
    ) u_load_align (
        .raw         (mem[idx]),
        .offset      (offset),
        .size        (Size),
        .signed_load (SignedLoad),
        .result      (load_result)
    );

    // Registered load path; sampling mem before the write gives read-first
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            ReadData    <= '0;
            ReadValid   <= 1'b0;
            AccessError <= 1'b0;
        end else begin
            ReadValid   <= do_read;
            AccessError <= (MemoryRead | MemoryWrite) & bad;
            if (do_read) begin
                ReadData <= load_result;
            end
        end
    end

endmodule

// File: tb/tb_byte_data_memory.sv
// Self-checking bench: 32- and 64-bit instances driven with the same
// directed and random accesses, compared against a byte-level memory model.
module tb_byte_data_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  addr;
    logic [63:0] wdata;
    logic        rd, wr, sgn;
    logic [1:0]  size;

    logic [31:0] rdata32;
    logic        rv32, err32;
    logic [63:0] rdata64;
    logic        rv64, err64;

    always #5 clk = ~clk;

    byte_data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut32 (
        .Clock(clk), .Reset_n(rst_n), .Address(addr), .WriteData(wdata[31:0]),
        .MemoryRead(rd), .MemoryWrite(wr), .Size(size), .SignedLoad(sgn),
        .ReadData(rdata32), .ReadValid(rv32), .AccessError(err32)
    );

    byte_data_memory #(.DATA_WIDTH(64), .ADDR_WIDTH(8)) dut64 (
        .Clock(clk), .Reset_n(rst_n), .Address(addr), .WriteData(wdata),
        .MemoryRead(rd), .MemoryWrite(wr), .Size(size), .SignedLoad(sgn),
        .ReadData(rdata64), .ReadValid(rv64), .AccessError(err64)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: index 0 is the 32-bit instance, index 1 the 64-bit instance
    logic [7:0]  mdl       [2][256];
    bit          known     [2][256];
    logic [63:0] exp_rdata [2];
    bit          exp_known [2];
    bit          exp_valid [2];
    bit          exp_err   [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, predict both instances, clock, compare
    task automatic step(input bit r, input bit w_, input logic [7:0] a,
                        input logic [1:0] s, input bit sg, input logic [63:0] d);
        rd = r; wr = w_; addr = a; size = s; sgn = sg; wdata = d;
        for (int w = 0; w < 2; w++) begin
            int          nb;
            bit          bad;
            bit          kn;
            logic [63:0] v;
            nb  = 1 << s;
            bad = ((int'(a) % nb) != 0) || (s == 2'd3 && w == 0);
            exp_valid[w] = rst_n && r && !bad;
            exp_err[w]   = rst_n && (r || w_) && bad;
            if (!rst_n) begin
                exp_rdata[w] = 64'd0;
                exp_known[w] = 1'b1;
            end else if (exp_valid[w]) begin
                v  = 64'd0;
                kn = 1'b1;
                for (int b = 0; b < nb; b++) begin
                    v  = v | (64'(mdl[w][int'(a) + b]) << (8 * b));
                    kn = kn & known[w][int'(a) + b];
                end
                if (sg && v[8*nb-1] && nb < 8) v = v | (~64'd0 << (8 * nb));
                exp_rdata[w] = (w == 1) ? v : (v & 64'h0000_0000_FFFF_FFFF);
                exp_known[w] = kn;
            end
            if (rst_n && w_ && !bad) begin
                for (int b = 0; b < nb; b++) begin
                    mdl[w][int'(a) + b]   = d[8*b +: 8];
                    known[w][int'(a) + b] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        check("valid32", 64'(rv32),  64'(exp_valid[0]));
        check("error32", 64'(err32), 64'(exp_err[0]));
        check("valid64", 64'(rv64),  64'(exp_valid[1]));
        check("error64", 64'(err64), 64'(exp_err[1]));
        if (exp_known[0]) check("rdata32", 64'(rdata32), exp_rdata[0]);
        if (exp_known[1]) check("rdata64", rdata64, exp_rdata[1]);
    endtask

    initial begin
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 256; i++) begin
                mdl[w][i]   = 8'h00;
                known[w][i] = 1'b0;
            end
            exp_rdata[w] = 64'd0;
            exp_known[w] = 1'b0;
        end
        rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = 8'h00; size = 2'd0; sgn = 1'b0; wdata = 64'd0;

        // Reset, including a store/load attempted during reset
        step(0, 0, 8'h00, 2'd0, 0, 64'd0);
        step(1, 1, 8'h10, 2'd2, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        check("reset_rdata32", 64'(rdata32), 64'd0);
        check("reset_valid32", 64'(rv32), 64'd0);
        rst_n = 1'b1;

        step(0, 1, 8'h10, 2'd2, 0, 64'h1122_3344);
        step(1, 0, 8'h10, 2'd2, 0, 64'd0);
        check("word_load", 64'(rdata32), 64'h1122_3344);
        check("word_load_valid", 64'(rv32), 64'd1);

        step(0, 1, 8'h11, 2'd0, 0, 64'hAB);
        step(1, 0, 8'h11, 2'd0, 1, 64'd0);
        check("byte_signed", 64'(rdata32), 64'hFFFF_FFAB);
        step(1, 0, 8'h11, 2'd0, 0, 64'd0);
        check("byte_unsigned", 64'(rdata32), 64'h0000_00AB);
        step(1, 0, 8'h10, 2'd2, 0, 64'd0);
        check("word_after_byte", 64'(rdata32), 64'h1122_AB44);

        step(1, 0, 8'h12, 2'd1, 0, 64'd0);
        check("half_unsigned", 64'(rdata32), 64'h0000_1122);
        step(0, 1, 8'h13, 2'd1, 0, 64'hBEEF);
        check("misaligned_err", 64'(err32), 64'd1);
        step(1, 0, 8'h10, 2'd2, 0, 64'd0);
        check("word_unchanged", 64'(rdata32), 64'h1122_AB44);

        step(1, 1, 8'h10, 2'd2, 0, 64'hDEAD_BEEF);
        check("read_first", 64'(rdata32), 64'h1122_AB44);
        step(1, 0, 8'h10, 2'd2, 0, 64'd0);
        check("after_rmw", 64'(rdata32), 64'hDEAD_BEEF);

        // Load followed immediately by reset
        step(1, 0, 8'h10, 2'd2, 0, 64'd0);
        rst_n = 1'b0;
        step(0, 0, 8'h10, 2'd2, 0, 64'd0);
        check("midreset_valid", 64'(rv32), 64'd0);
        check("midreset_rdata", 64'(rdata32), 64'd0);
        rst_n = 1'b1;
        step(1, 0, 8'h10, 2'd2, 0, 64'd0);
        check("retained", 64'(rdata32), 64'hDEAD_BEEF);

        step(0, 1, 8'h08, 2'd3, 0, 64'h0123_4567_89AB_CDEF);
        check("dword_illegal32", 64'(err32), 64'd1);
        check("dword_legal64", 64'(err64), 64'd0);
        step(1, 0, 8'h0C, 2'd2, 1, 64'd0);
        check("word_signed64", rdata64, 64'h0000_0000_0123_4567);

        // Random traffic, mostly aligned, with occasional reset
        for (int n = 0; n < 600; n++) begin
            logic [7:0]  ra;
            logic [1:0]  rs;
            logic [63:0] rdw;
            rs  = 2'($urandom_range(0, 3));
            ra  = 8'($urandom);
            if ($urandom_range(0, 3) != 0) ra = ra & ~8'((1 << rs) - 1);
            rdw = {32'($urandom), 32'($urandom)};
            rst_n = ($urandom_range(0, 49) != 0);
            step(1'($urandom), 1'($urandom), ra, rs, 1'($urandom), rdw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
